// File: rtl/console_tx_fifo.sv
// console_tx_fifo: byte FIFO draining into the simpleuart data register; CONSOLE_TX_CRLF_EN expands LF to CR LF
module console_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  uart_dat_we,
  output logic [31:0]           uart_dat_di,
  input  logic                  uart_dat_wait
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef CONSOLE_TX_CRLF_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, CR} state_t;
  logic cr_done, cr_done_n;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count_n;
  logic [31:0] head, di_n;
  logic push, pop, we_n;
  assign push = wr_en && !full;
  assign head = {{(32-DATA_WIDTH){1'b0}}, mem[rd_ptr]};
  assign count_n = count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      state       <= IDLE;
      uart_dat_we <= 1'b0;
      uart_dat_di <= '0;
`ifdef CONSOLE_TX_CRLF_EN
      cr_done     <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      count       <= count_n;
      full        <= count_n == (DEPTH_LOG2+1)'(DEPTH);
      empty       <= count_n == '0;
      state       <= state_n;
      uart_dat_we <= we_n;
      uart_dat_di <= di_n;
`ifdef CONSOLE_TX_CRLF_EN
      cr_done     <= cr_done_n;
`endif
    end
  end
  always_comb begin
    state_n = state;
    we_n    = uart_dat_we;
    di_n    = uart_dat_di;
    pop     = 1'b0;
`ifdef CONSOLE_TX_CRLF_EN
    cr_done_n = cr_done;
`endif
    case (state)
      IDLE:
        if (!empty) begin
          we_n = 1'b1;
`ifdef CONSOLE_TX_CRLF_EN
          // cr_done remembers the CR already went out for the LF still at the head
          if (mem[rd_ptr] == DATA_WIDTH'(8'h0A) && !cr_done) begin
            di_n    = 32'h0000_000D;
            state_n = CR;
          end else begin
            di_n    = head;
            state_n = SEND;
          end
`else
          di_n    = head;
          state_n = SEND;
`endif
        end
      SEND:
        if (!uart_dat_wait) begin
          pop     = 1'b1;
          we_n    = 1'b0;
          state_n = GAP;
`ifdef CONSOLE_TX_CRLF_EN
          cr_done_n = 1'b0;
`endif
        end
`ifdef CONSOLE_TX_CRLF_EN
      CR:
        if (!uart_dat_wait) begin
          we_n      = 1'b0;
          state_n   = GAP;
          cr_done_n = 1'b1;
        end
`endif
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_console_tx_fifo.sv
// tb_console_tx_fifo: scoreboard bench for console_tx_fifo; expected UART bytes queued at push, checked per accepted write
module tb_console_tx_fifo;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic full, empty, overflow, uart_dat_we;
  logic [4:0] count;
  logic [31:0] uart_dat_di;
  logic uart_dat_wait = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic prev_we = 1'b0;
  logic [31:0] prev_di = '0;

  console_tx_fifo dut (
    .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di), .uart_dat_wait(uart_dat_wait)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a write is accepted on the coming edge when we=1 and wait=0
  always @(negedge CLK) begin
    if (!rst) begin
      if (uart_dat_we && prev_we && uart_dat_di !== prev_di) begin
        vectors++;
        miscompares++;
        $display("FAIL di_stable: got %0h expected %0h", uart_dat_di, prev_di);
      end
      if (uart_dat_we && !uart_dat_wait) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got %0h expected none", uart_dat_di);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (uart_dat_di !== {24'b0, e}) begin
            miscompares++;
            $display("FAIL uart_write: got %0h expected %0h", uart_dat_di, {24'b0, e});
          end
        end
      end
    end
    prev_we = uart_dat_we;
    prev_di = uart_dat_di;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    wr_en = 1'b1;
    wr_data = b;
    if (keep) begin
`ifdef CONSOLE_TX_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_we(input int budget);
    for (int i = 0; i < budget && !uart_dat_we; i++) step();
    check("we_rise", {31'b0, uart_dat_we}, 32'd1);
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget && !(exp_q.size() == 0 && empty && !uart_dat_we); i++) step();
    check("drain_done", {31'b0, i < budget}, 32'd1);
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    step();
    step();
    check("rst_count", {27'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_we", {31'b0, uart_dat_we}, 32'd0);
    check("rst_di", uart_dat_di, 32'd0);
    rst = 1'b0;
    step();
    // single byte latency: pushed at edge N, we high after N+1 for one cycle
    push(8'h41, 1'b1);
    check("t1_we_after_push", {31'b0, uart_dat_we}, 32'd0);
    check("t1_count_after_push", {27'b0, count}, 32'd1);
    step();
    check("t1_we_rise", {31'b0, uart_dat_we}, 32'd1);
    check("t1_di", uart_dat_di, 32'h41);
    step();
    check("t1_we_fall", {31'b0, uart_dat_we}, 32'd0);
    check("t1_count", {27'b0, count}, 32'd0);
    check("t1_empty", {31'b0, empty}, 32'd1);
    repeat (3) step();
    // three bytes with a slow UART
    uart_dat_wait = 1'b1;
    push(8'h48, 1'b1);
    push(8'h69, 1'b1);
    push(8'h21, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_we(20);
      repeat (10) begin
        step();
        check("t2_we_hold", {31'b0, uart_dat_we}, 32'd1);
      end
      uart_dat_wait = 1'b0;
      step();
      uart_dat_wait = 1'b1;
    end
    repeat (4) step();
    check("t2_queue_empty", exp_q.size(), 32'd0);
    check("t2_fifo_empty", {31'b0, empty}, 32'd1);
    // fill to full and overflow while the UART stalls
    for (int b = 0; b < 16; b++) push(8'(b), 1'b1);
    check("t3_full", {31'b0, full}, 32'd1);
    check("t3_count16", {27'b0, count}, 32'd16);
    check("t3_no_ovf_yet", {31'b0, overflow}, 32'd0);
    push(8'h10, 1'b0);
    check("t3_overflow", {31'b0, overflow}, 32'd1);
    check("t3_count_kept", {27'b0, count}, 32'd16);
    uart_dat_wait = 1'b0;
    drain(200);
    check("t3_overflow_sticky", {31'b0, overflow}, 32'd1);
    check("t3_queue_empty", exp_q.size(), 32'd0);
    // pointer wrap with two full batches
    for (int b = 0; b < 16; b++) push(8'h80 + 8'(b), 1'b1);
    drain(200);
    for (int b = 0; b < 16; b++) push(8'hC0 + 8'(b), 1'b1);
    drain(200);
    check("t4_queue_empty", exp_q.size(), 32'd0);
    check("t4_count", {27'b0, count}, 32'd0);
    // reset mid-SEND with 5 queued
    uart_dat_wait = 1'b1;
    for (int b = 0; b < 5; b++) push(8'h30 + 8'(b), 1'b1);
    step();
    check("t5_in_send", {31'b0, uart_dat_we}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("t5_we", {31'b0, uart_dat_we}, 32'd0);
    check("t5_count", {27'b0, count}, 32'd0);
    check("t5_empty", {31'b0, empty}, 32'd1);
    check("t5_overflow", {31'b0, overflow}, 32'd0);
    uart_dat_wait = 1'b0;
    repeat (20) step();
    check("t5_quiet", {31'b0, uart_dat_we}, 32'd0);
    // line feed handling
    push(8'h61, 1'b1);
    push(8'h0A, 1'b1);
    drain(100);
    check("t6_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/console_tx_fifo.md
Name: console_tx_fifo

Overview:
- Byte-wide transmit buffer between the CPU's console-write instruction (B2) and the simpleuart data register.
- The CPU pushes bytes in a single cycle and never stalls on the slow 300-baud UART, unless the buffer is full.
- A drain state machine pops bytes and performs the simpleuart write handshake: hold reg_dat_we until reg_dat_wait drops.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 = 16 entries
- DATA_WIDTH, 8, byte width; value zero-extended onto the 32-bit UART data bus

Ports:
- CLK  input  1  system clock (16 MHz)
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  push request from CPU, one cycle per byte
- wr_data  input  DATA_WIDTH  byte to push
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was attempted while full
- uart_dat_we  output  1  to simpleuart reg_dat_we
- uart_dat_di  output  32  to simpleuart reg_dat_di
- uart_dat_wait  input  1  from simpleuart reg_dat_wait

Behaviour:
- Reset values:
  - Reset is synchronous, active-high: all state updates on the CLK rising edge while rst=1.
  - Pointers = 0, count = 0, empty = 1, full = 0, overflow = 0.
  - uart_dat_we = 0, uart_dat_di = 0, FSM = IDLE.
- Storage:
  - Circular buffer with wr_ptr and rd_ptr of DEPTH_LOG2 bits; both wrap naturally from DEPTH-1 to 0.
  - count is tracked separately so full and empty are unambiguous.
- Push:
  - Accepted on an edge where wr_en=1 and full=0 (full sampled before the edge).
  - On acceptance: mem[wr_ptr] <= wr_data, wr_ptr+1, count+1.
- Push while full:
  - Data is dropped; pointers and count are unchanged; overflow <= 1.
  - This holds even if a pop occurs on the same edge.
- Push and pop on the same edge (not full): both take effect and count is unchanged.
- Outputs: full, empty and count are registered and reflect state after each edge.
- Drain FSM states:
  - IDLE: if !empty, load uart_dat_di <= {24'b0, mem[rd_ptr]}, set uart_dat_we <= 1, go to SEND. If empty, stay in IDLE with uart_dat_we=0.
  - SEND: uart_dat_we and uart_dat_di are held stable. On an edge with uart_dat_wait=0 the UART has accepted the byte: rd_ptr+1, count-1, uart_dat_we <= 0, go to GAP. While uart_dat_wait=1, remain in SEND.
  - GAP: one-cycle deassertion of uart_dat_we, so each byte is a distinct write pulse; then go to IDLE.
- Latency:
  - Byte pushed into an empty FIFO at edge N: uart_dat_we rises at edge N+1.
  - Back-to-back bytes are spaced at minimum 3 cycles (SEND, GAP, IDLE) when the UART never waits.
- Ordering: strict FIFO; no byte is dropped or duplicated except by overflow.
- Reset mid-operation:
  - rst during SEND forces uart_dat_we low at that edge; the in-flight byte is discarded.
  - The FIFO is emptied and overflow is cleared.
- uart_dat_di is don't-care outside SEND but retains its last value; it does not toggle spuriously.

Optional Feature:
- Macro: CONSOLE_TX_CRLF_EN.
- Defined:
  - When the head byte is 0x0A, IDLE first emits 0x0D through a CR state.
  - The CR state runs the same handshake as SEND, without popping, then passes through GAP.
  - It then emits 0x0A through SEND, which pops.
  - A pushed 0x0A therefore produces two UART writes: 0x0D, then 0x0A.
  - count and full reflect stored bytes only.
- Undefined: bytes pass through verbatim; the CR state is not built.

Test Plan:
- Reset, push 0x41 at edge N, uart_dat_wait held 0 -> uart_dat_we=1 with uart_dat_di=0x00000041 from edge N+1 for exactly one cycle; count returns to 0; empty=1.
- Push 0x48, 0x69, 0x21 on consecutive edges, uart_dat_wait=1 for 10 cycles after each we rise -> three writes in order 0x48, 0x69, 0x21; uart_dat_we held steady while wait=1; di never changes mid-SEND.
- With uart_dat_wait stuck at 1, push 17 bytes (0x00..0x10) -> full=1 and count=16 after the 16th push; 17th dropped and overflow=1; release wait -> exactly 0x00..0x0F emitted, overflow stays 1.
- Push 16 bytes, drain 16, push 16 more -> pointer wrap; second batch emitted intact and in order.
- Assert rst for one cycle while in SEND with 5 bytes queued -> uart_dat_we=0, count=0, empty=1, overflow=0 next cycle; no further UART writes.
- With CONSOLE_TX_CRLF_EN defined, push 0x61, 0x0A -> UART writes 0x61, 0x0D, 0x0A. Without the macro -> 0x61, 0x0A.
